ps2_tecla_rx: RTL and testbench

//  PS/2 keyboard receiver and key-state tracker feeding the sine generator's 8-bit code input.
//  - Samples the raw PS/2 clock/data lines and deframes 11-bit frames.
//  - Resolves make, break (F0) and extended (E0) sequences into one "currently held key" code.
//  - Output is 0x00 when no key is held; the sine generator treats 0x00 as its default tone.

---
 rtl/ps2_tecla_rx_pkg.sv | 27 ++
 rtl/ps2_tecla_rx_if.sv | 13 +
 rtl/ps2_tecla_rx_frame_rx.sv | 98 +++++++++
 rtl/ps2_tecla_rx.sv | 82 ++++++++
 tb/tb_ps2_tecla_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_tecla_rx_pkg.sv
// Shared constants, state encodings and byte classification for the PS/2 key receiver.
package ps2_tecla_rx_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;
  localparam logic [7:0] CODE_NONE  = 8'h00;

  typedef enum logic [1:0] {FrmIdle, FrmData, FrmParity, FrmStop} frame_state_e;
  typedef enum logic [1:0] {DecNorm, DecBrk, DecExt, DecExtBrk} dec_state_e;

  // Keyboard housekeeping bytes that never represent a key.
  function automatic logic is_ignored(input logic [7:0] b);
    logic r;
    case (b)
      PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_OVR_LO, PS2_OVR_HI: r = 1'b1;
      default:                                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_tecla_rx_if.sv
// PS/2 line pair plus the key-code result seen by the downstream tone generator.
interface ps2_tecla_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] codigo;
  logic       code_new;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input codigo, input code_new, input frame_err);
  modport slave  (input ps2_clk, input ps2_data,
                  output codigo, output code_new, output frame_err);
endinterface

// File: rtl/ps2_tecla_rx_frame_rx.sv
// Bit-level PS/2 receiver: synchronisers, falling-edge detect, 11-bit deframing and watchdog.
module ps2_tecla_rx_frame_rx
  import ps2_tecla_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  frame_state_e           r_state, w_state_d;
  logic [7:0]             r_shift, w_shift_d;
  logic [2:0]             r_bitcnt, w_bitcnt_d;
  logic                   r_par_ok, w_par_ok_d;
  logic [WdW-1:0]         r_wd, w_wd_d;
  logic                   w_clk_s, w_dat_s, w_fall, w_timeout;

  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
  assign w_fall    = r_clk_prev & ~w_clk_s;
  assign w_timeout = (r_state != FrmIdle) && (r_wd == WdW'(TIMEOUT_CYC));

  // Synchronisers preload to the idle bus level so release from reset is not seen as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
      r_state    <= FrmIdle;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_par_ok   <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev <= w_clk_s;
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bitcnt   <= w_bitcnt_d;
      r_par_ok   <= w_par_ok_d;
      r_wd       <= w_wd_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_bitcnt_d   = r_bitcnt;
    w_par_ok_d   = r_par_ok;
    w_wd_d       = (r_state == FrmIdle || w_fall) ? '0 : r_wd + WdW'(1);
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    if (w_fall) begin
      unique case (r_state)
        FrmIdle: begin
          if (!w_dat_s) begin
            w_state_d  = FrmData;
            w_bitcnt_d = '0;
          end else begin
            o_frame_err = 1'b1;
          end
        end
        FrmData: begin
          w_shift_d  = {w_dat_s, r_shift[7:1]};
          w_bitcnt_d = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_d = FrmParity;
        end
        FrmParity: begin
          w_par_ok_d = ^{r_shift, w_dat_s};
          w_state_d  = FrmStop;
        end
        FrmStop: begin
          if (w_dat_s && r_par_ok) o_byte_valid = 1'b1;
          else                     o_frame_err  = 1'b1;
          w_state_d = FrmIdle;
        end
      endcase
    end else if (w_timeout) begin
      o_frame_err = 1'b1;
      w_state_d   = FrmIdle;
      w_wd_d      = '0;
    end
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/ps2_tecla_rx.sv
// PS/2 keyboard receiver: turns make/break/extended sequences into the currently held key code.
module ps2_tecla_rx
  import ps2_tecla_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ps2_tecla_rx_if.slave  io_ps2
);

  logic [7:0] w_byte;
  logic       w_byte_valid, w_frame_err;
  dec_state_e r_dec, w_dec_d;
  logic [7:0] r_codigo, w_codigo_d;
  logic       r_code_new, w_code_new_d;
  logic       r_frame_err;

  ps2_tecla_rx_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ps2_clk    (io_ps2.ps2_clk),
    .i_ps2_data   (io_ps2.ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dec       <= DecNorm;
      r_codigo    <= CODE_NONE;
      r_code_new  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dec       <= w_dec_d;
      r_codigo    <= w_codigo_d;
      r_code_new  <= w_code_new_d;
      r_frame_err <= w_frame_err;
    end
  end

  // Frame errors never touch the decoder; only complete bytes advance it.
  always_comb begin
    w_dec_d      = r_dec;
    w_codigo_d   = r_codigo;
    w_code_new_d = 1'b0;
    if (w_byte_valid) begin
      unique case (r_dec)
        DecNorm: begin
          if (w_byte == PS2_BREAK) begin
            w_dec_d = DecBrk;
          end else if (w_byte == PS2_EXT) begin
            w_dec_d = DecExt;
          end else if (!is_ignored(w_byte)) begin
            w_codigo_d   = w_byte;
            w_code_new_d = (w_byte != r_codigo);
          end
        end
        DecBrk: begin
          w_dec_d = DecNorm;
          // Only releasing the most recently pressed key silences the output.
          if (w_byte == r_codigo && r_codigo != CODE_NONE) begin
            w_codigo_d   = CODE_NONE;
            w_code_new_d = 1'b1;
          end
        end
        DecExt:    w_dec_d = (w_byte == PS2_BREAK) ? DecExtBrk : DecNorm;
        DecExtBrk: w_dec_d = DecNorm;
      endcase
    end
  end

  assign io_ps2.codigo    = r_codigo;
  assign io_ps2.code_new  = r_code_new;
  assign io_ps2.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_tecla_rx.sv
// Bench for ps2_tecla_rx: drives PS/2 frames and scores every code_new against a queue.
module tb_ps2_tecla_rx;

  localparam int unsigned Half     = 20;
  localparam int unsigned Timeout  = 200;
  localparam int          MGood    = 0;
  localparam int          MBadPar  = 1;
  localparam int          MBadStop = 2;
  localparam int          MStall   = 3;
  localparam int          MCut     = 4;
  localparam int          MStart   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_tecla_rx_if ps2_if ();

  ps2_tecla_rx #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_ps2  (ps2_if)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_ferr   = 0;
  int         exp_ferr = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every code_new pulse must match the next queued code; 0x1FF marks an unexpected pulse.
  always @(negedge clk) begin
    if (ps2_if.code_new === 1'b1) begin
      exp_code = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
      check("code_new", {24'h0, ps2_if.codigo}, {23'h0, exp_code});
    end
    if (ps2_if.frame_err === 1'b1) n_ferr++;
  end

  task automatic ps2_bit(input logic b);
    ps2_if.ps2_data = b;
    repeat (Half / 2) @(posedge clk);
    ps2_if.ps2_clk = 1'b0;
    repeat (Half) @(posedge clk);
    ps2_if.ps2_clk = 1'b1;
    repeat (Half / 2) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int mode);
    logic par;
    par = ~^b;
    if (mode == MStart) begin
      ps2_bit(1'b1);
      repeat (3 * Half) @(posedge clk);
      return;
    end
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (mode == MStall && i == 4) begin
        repeat (2 * Timeout) @(posedge clk);
        ps2_if.ps2_data = 1'b1;
        repeat (3 * Half) @(posedge clk);
        return;
      end
      if (mode == MCut && i == 5) return;
      ps2_bit(b[i]);
    end
    ps2_bit((mode == MBadPar) ? ~par : par);
    ps2_bit((mode == MBadStop) ? 1'b0 : 1'b1);
    ps2_if.ps2_data = 1'b1;
    repeat (3 * Half) @(posedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, MGood);
  endtask

  task automatic expect_code(input logic [7:0] v);
    sb.push_back({1'b0, v});
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    ps2_if.ps2_clk  = 1'b1;
    ps2_if.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_codigo", {24'h0, ps2_if.codigo}, 32'h00);
    check("rst_code_new", {31'h0, ps2_if.code_new}, 32'h0);
    check("rst_frame_err", {31'h0, ps2_if.frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single make code
    expect_code(8'h15);
    key(8'h15);
    check("t1_codigo", {24'h0, ps2_if.codigo}, 32'h15);
    check("t1_ferr", n_ferr, exp_ferr);

    // Release, then typematic repeat stays silent
    expect_code(8'h00);
    key(8'hF0); key(8'h15);
    expect_code(8'h15);
    key(8'h15); key(8'h15); key(8'h15);
    check("t2_held", {24'h0, ps2_if.codigo}, 32'h15);
    expect_code(8'h00);
    key(8'hF0); key(8'h15);
    check("t2_released", {24'h0, ps2_if.codigo}, 32'h00);

    // Last make wins; releasing the older key keeps the newer one
    expect_code(8'h1D);
    key(8'h1D);
    expect_code(8'h24);
    key(8'h24);
    key(8'hF0); key(8'h1D);
    check("t3_older_rel", {24'h0, ps2_if.codigo}, 32'h24);
    expect_code(8'h00);
    key(8'hF0); key(8'h24);
    check("t3_released", {24'h0, ps2_if.codigo}, 32'h00);

    // Extended make/break sequences never change the code
    expect_code(8'h2C);
    key(8'h2C);
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    check("t4_ext", {24'h0, ps2_if.codigo}, 32'h2C);
    key(8'hAA); key(8'hFA);
    check("t4_ignored", {24'h0, ps2_if.codigo}, 32'h2C);

    // Framing errors: parity, stop, start, watchdog
    send(8'h1C, MBadPar);  exp_ferr++;
    check("t5_badpar_code", {24'h0, ps2_if.codigo}, 32'h2C);
    check("t5_badpar_ferr", n_ferr, exp_ferr);
    send(8'h1C, MBadStop); exp_ferr++;
    check("t5_badstop_ferr", n_ferr, exp_ferr);
    send(8'h00, MStart);   exp_ferr++;
    check("t5_start_ferr", n_ferr, exp_ferr);
    send(8'h1C, MStall);   exp_ferr++;
    check("t5_stall_ferr", n_ferr, exp_ferr);
    expect_code(8'h1B);
    key(8'h1B);
    check("t5_recover", {24'h0, ps2_if.codigo}, 32'h1B);
    // An error after the E0 prefix leaves the prefix pending
    key(8'hE0);
    send(8'h33, MBadPar);  exp_ferr++;
    key(8'h75);
    check("t5_prefix_kept", {24'h0, ps2_if.codigo}, 32'h1B);
    check("t5_ferr_total", n_ferr, exp_ferr);

    // Asynchronous reset mid-frame
    expect_code(8'h43);
    key(8'h43);
    check("t6_pre", {24'h0, ps2_if.codigo}, 32'h43);
    send(8'h5A, MCut);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_codigo", {24'h0, ps2_if.codigo}, 32'h00);
    check("t6_async_code_new", {31'h0, ps2_if.code_new}, 32'h0);
    ps2_if.ps2_clk  = 1'b1;
    ps2_if.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    expect_code(8'h44);
    key(8'h44);
    check("t6_after", {24'h0, ps2_if.codigo}, 32'h44);

    repeat (20) @(posedge clk);
    check("sb_empty", sb.size(), 32'h0);
    check("ferr_final", n_ferr, exp_ferr);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
